// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencing controller: drives PC hold/select, runs a single-outstanding
// imem request handshake, buffers the fetched instruction and applies redirects.
module pc_fetch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  cur_pc,
  output logic             stop_en,
  output logic             pc_sel,
  output logic [XLEN-1:0]  branch_tgt,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             dec_stall,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_instr,
  output logic [XLEN-1:0]  if_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  // imem handshake: a request transfers on a cycle where imem_req && imem_ready;
  // its single response is the next cycle with imem_rvalid=1 (no ready on the
  // response side). Only one request is ever outstanding.
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_VALID = 3'd2,
    S_DROP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   pc_misaligned;

  assign pc_misaligned = (cur_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stop_en    = 1'b1;
    pc_sel     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = cur_pc;
    branch_tgt = redirect_pc;
    if (rst) begin
      state_d = S_REQ;
    end else if (redirect_valid) begin
      pc_sel  = 1'b1;
      stop_en = 1'b0;
      // A fetch still in flight must have its response swallowed in DROP.
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) state_d = S_DROP;
      else                                                         state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (pc_misaligned) begin
            state_d = S_ERR;
          end else begin
            imem_req = 1'b1;
            if (imem_ready) state_d = S_WAIT;
          end
        end
        S_WAIT:  if (imem_rvalid) state_d = S_VALID;
        S_VALID: begin
          stop_en = dec_stall;
          if (!dec_stall) state_d = S_REQ;
        end
        S_DROP:  if (imem_rvalid) state_d = S_REQ;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else if (redirect_valid) begin
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: if (pc_misaligned) misalign_err <= 1'b1;
        S_WAIT: begin
          if (imem_rvalid) begin
            if_instr <= imem_rdata;
            if_pc    <= cur_pc;
            if_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (!dec_stall) begin
            if_valid  <= 1'b0;
            fetch_cnt <= fetch_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a PC register model and a simple imem
// responder (automatic one-cycle response or manually driven).
module tb_pc_fetch_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XLEN-1:0]  cur_pc = '0;
  logic             stop_en, pc_sel, imem_req;
  logic [XLEN-1:0]  branch_tgt, imem_addr, if_instr, if_pc;
  logic             redirect_valid = 1'b0;
  logic [XLEN-1:0]  redirect_pc = '0;
  logic             imem_ready = 1'b1;
  logic             imem_rvalid;
  logic [XLEN-1:0]  imem_rdata;
  logic             dec_stall = 1'b0;
  logic             if_valid, misalign_err;
  logic [CNT_W-1:0] fetch_cnt;

  logic             auto_mode = 1'b1;
  logic             auto_rv = 1'b0;
  logic [XLEN-1:0]  auto_data = 32'h0000_0013;
  logic             man_rv = 1'b0;
  logic [XLEN-1:0]  man_data = '0;

  int errors = 0;
  int checks = 0;

  assign imem_rvalid = auto_mode ? auto_rv   : man_rv;
  assign imem_rdata  = auto_mode ? auto_data : man_data;

  pc_fetch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cur_pc(cur_pc), .stop_en(stop_en), .pc_sel(pc_sel),
    .branch_tgt(branch_tgt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_stall(dec_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // PC register model: hold, load target, or step by 4.
  always @(posedge clk) begin
    if (rst)          cur_pc <= '0;
    else if (stop_en) cur_pc <= cur_pc;
    else if (pc_sel)  cur_pc <= branch_tgt;
    else              cur_pc <= cur_pc + 32'd4;
  end

  always @(posedge clk) auto_rv <= auto_mode && imem_req && imem_ready && !rst;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; man_rv = 1'b0; dec_stall = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; imem_ready = 1'b1;
    tick(); settle();
    checks++; if (stop_en !== 1'b1) begin errors++; $display("FAIL rst_stop_en got=%b exp=1", stop_en); end
    checks++; if (pc_sel !== 1'b0) begin errors++; $display("FAIL rst_pc_sel got=%b exp=0", pc_sel); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0; settle();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_fetch_cnt got=%0d exp=0", fetch_cnt); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_sequence();
    do_reset();
    auto_mode = 1'b1;
    for (int c = 0; c < 9; c++) begin
      settle();
      checks++;
      if (stop_en !== ((c % 3) != 2)) begin errors++; $display("FAIL seq_stop_en c=%0d got=%b exp=%b", c, stop_en, (c % 3) != 2); end
      if (c % 3 == 0) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c / 3))) begin
          errors++; $display("FAIL seq_req c=%0d req=%b addr=%h exp req=1 addr=%h", c, imem_req, imem_addr, 4 * (c / 3));
        end
      end
      if (c % 3 == 2) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (c / 3)) || if_instr !== 32'h13) begin
          errors++; $display("FAIL seq_if c=%0d v=%b pc=%h instr=%h exp v=1 pc=%h instr=13", c, if_valid, if_pc, if_instr, 4 * (c / 3));
        end
      end
      tick();
    end
    settle();
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_fetch_cnt got=%0d exp=3", fetch_cnt); end
    checks++; if (cur_pc !== 32'hC) begin errors++; $display("FAIL seq_pc got=%h exp=c", cur_pc); end
  endtask

  task automatic test_dec_stall();
    do_reset();
    auto_mode = 1'b1;
    repeat (5) tick();
    dec_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (stop_en !== 1'b1 || if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h13 || fetch_cnt !== 32'd1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c=%0d stop=%b v=%b pc=%h instr=%h cnt=%0d req=%b exp stop=1 v=1 pc=4 instr=13 cnt=1 req=0",
                 c, stop_en, if_valid, if_pc, if_instr, fetch_cnt, imem_req);
      end
      tick();
    end
    dec_stall = 1'b0; settle();
    checks++; if (stop_en !== 1'b0) begin errors++; $display("FAIL stall_release_stop got=%b exp=0", stop_en); end
    tick(); settle();
    checks++;
    if (cur_pc !== 32'h8 || fetch_cnt !== 32'd2 || if_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL stall_advance pc=%h cnt=%0d v=%b req=%b exp pc=8 cnt=2 v=0 req=1", cur_pc, fetch_cnt, if_valid, imem_req);
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    auto_mode = 1'b0; man_rv = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; settle();
    checks++;
    if (pc_sel !== 1'b1 || stop_en !== 1'b0 || imem_req !== 1'b0 || branch_tgt !== 32'h100) begin
      errors++; $display("FAIL redir_ctl sel=%b stop=%b req=%b tgt=%h exp sel=1 stop=0 req=0 tgt=100", pc_sel, stop_en, imem_req, branch_tgt);
    end
    tick();
    redirect_valid = 1'b0; settle();
    checks++;
    if (stop_en !== 1'b1 || imem_req !== 1'b0 || cur_pc !== 32'h100) begin
      errors++; $display("FAIL redir_drop stop=%b req=%b pc=%h exp stop=1 req=0 pc=100", stop_en, imem_req, cur_pc);
    end
    tick();
    man_rv = 1'b1; man_data = 32'hDEAD_BEEF; settle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_drop2_req got=%b exp=0", imem_req); end
    tick();
    man_rv = 1'b0; settle();
    checks++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_after v=%b instr=%h req=%b addr=%h exp v=0 instr=0 req=1 addr=100", if_valid, if_instr, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_same_cycle();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h180; man_rv = 1'b1; man_data = 32'hCAFE_0001;
    tick();
    redirect_valid = 1'b0; man_rv = 1'b0; settle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h180 || if_valid !== 1'b0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL same_cycle req=%b addr=%h v=%b instr=%h exp req=1 addr=180 v=0 instr=0", imem_req, imem_addr, if_valid, if_instr);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0; settle();
    checks++;
    if (imem_req !== 1'b0 || stop_en !== 1'b1 || cur_pc !== 32'h102) begin
      errors++; $display("FAIL mis_req req=%b stop=%b pc=%h exp req=0 stop=1 pc=102", imem_req, stop_en, cur_pc);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0 || stop_en !== 1'b1) begin
        errors++; $display("FAIL mis_err c=%0d err=%b req=%b stop=%b exp err=1 req=0 stop=1", c, misalign_err, imem_req, stop_en);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
    checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL mis_exit_sel got=%b exp=1", pc_sel); end
    tick();
    redirect_valid = 1'b0; settle();
    checks++;
    if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL mis_clear err=%b req=%b addr=%h exp err=0 req=1 addr=200", misalign_err, imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    imem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200 || stop_en !== 1'b1) begin
        errors++; $display("FAIL ready_hold c=%0d req=%b addr=%h stop=%b exp req=1 addr=200 stop=1", c, imem_req, imem_addr, stop_en);
      end
      tick();
    end
    imem_ready = 1'b1;
    tick();
    settle();
    checks++; if (imem_req !== 1'b0 || stop_en !== 1'b1) begin errors++; $display("FAIL ready_wait req=%b stop=%b exp req=0 stop=1", imem_req, stop_en); end
    man_rv = 1'b1; man_data = 32'h00A0_0093;
    tick();
    man_rv = 1'b0; dec_stall = 1'b1; settle();
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h00A0_0093 || if_pc !== 32'h200) begin
      errors++; $display("FAIL ready_capture v=%b instr=%h pc=%h exp v=1 instr=00a00093 pc=200", if_valid, if_instr, if_pc);
    end
    dec_stall = 1'b0;
    tick();
    auto_mode = 1'b1; settle();
    checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL b2b_cnt got=%0d exp=1", fetch_cnt); end
    tick(); tick(); settle();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h204) begin errors++; $display("FAIL b2b_valid v=%b pc=%h exp v=1 pc=204", if_valid, if_pc); end
    rst = 1'b1;
    tick(); settle();
    checks++;
    if (if_valid !== 1'b0 || fetch_cnt !== 32'd0 || stop_en !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset v=%b cnt=%0d stop=%b req=%b exp v=0 cnt=0 stop=1 req=0", if_valid, fetch_cnt, stop_en, imem_req);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_dec_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_misalign();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
